// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard and control unit.
package hazard_pkg;
    typedef enum logic [1:0] {
        SEQUENCE   = 2'b00,
        BRANCH     = 2'b01,
        NOT_BRANCH = 2'b10,
        JUMP       = 2'b11
    } next_pc_e;
    localparam logic [1:0] MUX_PC4    = 2'b00;
    localparam logic [1:0] MUX_BRANCH = 2'b01;
    localparam logic [1:0] MUX_JUMP   = 2'b10;
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hazard_state_e;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: multiply/divide busy interlock counter; busy is visible in the issue cycle itself.
module md_busy_counter #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    output logic o_busy
);
    localparam int W = $clog2(MD_LATENCY + 1);
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt;
    // A start reloads to MD_LATENCY this cycle, so a HI/LO reader frees up MD_LATENCY cycles later.
    assign w_cnt  = i_load ? W'(MD_LATENCY) : r_cnt;
    assign o_busy = w_cnt != '0;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= o_busy ? w_cnt - W'(1) : w_cnt;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, mult/div and mem-wait interlocks plus redirect flush control.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W          = 5,
    parameter int LOAD_STALL_CYC = 1,
    parameter int MD_LATENCY     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       branch_Or_Jump,
    input  logic             ID_EX_MemRead,
    input  logic [REG_W-1:0] ID_EX_Rt,
    input  logic [REG_W-1:0] IF_ID_Rs,
    input  logic [REG_W-1:0] IF_ID_Rt,
    input  logic             IF_ID_UsesRs,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_UsesHiLo,
    input  logic             MD_Start,
    input  logic             EX_MEM_MemAccess,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic [1:0]       PC_Mux_select,
    output logic             IF_ID_Stall,
    output logic             ID_EX_Stall,
    output logic             EX_MEM_Stall,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [1:0]       Hazard_State
);
    hazard_state_e r_state;
    hazard_state_e r_ret_state;
    hazard_state_e w_eff;
    logic [1:0]    r_lu_cnt;
    logic          w_md_busy;
    logic          w_mem_wait;
    logic          w_lu_hit;
    logic          w_lu_start;
    logic          w_bubble;
    md_busy_counter #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk    (clk),
        .rst    (rst),
        .i_load (MD_Start),
        .o_busy (w_md_busy)
    );
    assign w_mem_wait = EX_MEM_MemAccess && !Mem_Ready;
    assign w_lu_hit   = ID_EX_MemRead && ID_EX_Rt != '0 &&
                        ((IF_ID_UsesRs && IF_ID_Rs == ID_EX_Rt) || (IF_ID_UsesRt && IF_ID_Rt == ID_EX_Rt));
    // Once memory is ready, MEM_WAIT behaves as the state it interrupted, in that same cycle.
    assign w_eff        = r_state == MEM_WAIT ? r_ret_state : r_state;
    assign w_lu_start   = w_eff == IDLE && w_lu_hit;
    assign w_bubble     = w_eff == LU_STALL || w_lu_start || (w_md_busy && IF_ID_UsesHiLo);
    assign Hazard_State = r_state;
    always_comb begin
        PC_Write      = DISABLE;
        PC_Mux_select = MUX_PC4;
        IF_ID_Stall   = DISABLE;
        ID_EX_Stall   = DISABLE;
        EX_MEM_Stall  = DISABLE;
        IF_ID_Flush   = DISABLE;
        ID_EX_Flush   = DISABLE;
        if (rst) begin
            IF_ID_Flush = ENABLE;
            ID_EX_Flush = ENABLE;
        end else if (w_mem_wait) begin
            IF_ID_Stall  = ENABLE;
            ID_EX_Stall  = ENABLE;
            EX_MEM_Stall = ENABLE;
        end else if (w_bubble) begin
            IF_ID_Stall = ENABLE;
            ID_EX_Flush = ENABLE;
        end else begin
            PC_Write      = ENABLE;
            PC_Mux_select = branch_Or_Jump == NOT_BRANCH ? MUX_BRANCH :
                            branch_Or_Jump == JUMP       ? MUX_JUMP   : MUX_PC4;
            IF_ID_Flush   = branch_Or_Jump[1];
            ID_EX_Flush   = branch_Or_Jump[1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ret_state <= IDLE;
            r_lu_cnt    <= '0;
        end else if (w_mem_wait) begin
            r_state     <= MEM_WAIT;
            r_ret_state <= w_eff;
        end else if (w_eff == LU_STALL) begin
            r_lu_cnt <= r_lu_cnt - 2'd1;
            r_state  <= r_lu_cnt == 2'd1 ? IDLE : LU_STALL;
        end else if (w_lu_start && LOAD_STALL_CYC > 1) begin
            r_state  <= LU_STALL;
            r_lu_cnt <= 2'(LOAD_STALL_CYC - 1);
        end else begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with a queued scoreboard and a negedge monitor.
module tb_pipeline_hazard_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0, S_LU = 2'd1, S_MW = 2'd2;
    // {PC_Write, mux[1:0], IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush}
    localparam logic [7:0] O_RST = 8'b0_00_000_11;
    localparam logic [7:0] O_RUN = 8'b1_00_000_00;
    localparam logic [7:0] O_BUB = 8'b0_00_100_01;
    localparam logic [7:0] O_MEM = 8'b0_00_111_00;
    localparam logic [7:0] O_NB  = 8'b1_01_000_11;
    localparam logic [7:0] O_JMP = 8'b1_10_000_11;
    typedef struct {
        string      name;
        logic [9:0] exp;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] branch_Or_Jump;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_Rt, IF_ID_Rs, IF_ID_Rt;
    logic       IF_ID_UsesRs, IF_ID_UsesRt, IF_ID_UsesHiLo;
    logic       MD_Start, EX_MEM_MemAccess, Mem_Ready;
    logic       PC_Write, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush;
    logic [1:0] PC_Mux_select, Hazard_State;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    pipeline_hazard_ctrl #(.REG_W(5), .LOAD_STALL_CYC(2), .MD_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .branch_Or_Jump(branch_Or_Jump),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
        .IF_ID_UsesRs(IF_ID_UsesRs), .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_UsesHiLo(IF_ID_UsesHiLo),
        .MD_Start(MD_Start), .EX_MEM_MemAccess(EX_MEM_MemAccess), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .PC_Mux_select(PC_Mux_select),
        .IF_ID_Stall(IF_ID_Stall), .ID_EX_Stall(ID_EX_Stall), .EX_MEM_Stall(EX_MEM_Stall),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Hazard_State(Hazard_State)
    );
    task automatic clear_in();
        branch_Or_Jump = 2'b00; ID_EX_MemRead = 1'b0; ID_EX_Rt = '0; IF_ID_Rs = '0; IF_ID_Rt = '0;
        IF_ID_UsesRs = 1'b0; IF_ID_UsesRt = 1'b0; IF_ID_UsesHiLo = 1'b0; MD_Start = 1'b0;
        EX_MEM_MemAccess = 1'b0; Mem_Ready = 1'b1;
    endtask
    task automatic expect_cyc(input string n, input logic [1:0] st, input logic [7:0] o);
        sb.push_back('{n, {st, o}});
        @(posedge clk);
        #1;
    endtask
    task automatic load_use_rs8();
        ID_EX_MemRead = 1'b1; ID_EX_Rt = 5'd8; IF_ID_Rs = 5'd8; IF_ID_UsesRs = 1'b1;
    endtask
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e = sb.pop_front();
            act = {Hazard_State, PC_Write, PC_Mux_select, IF_ID_Stall, ID_EX_Stall, EX_MEM_Stall, IF_ID_Flush, ID_EX_Flush};
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got state/outputs %b_%b required %b_%b", e.name, act[9:8], act[7:0], e.exp[9:8], e.exp[7:0]);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1;
        clear_in();
        @(posedge clk);
        #1;
        expect_cyc("reset", S_IDLE, O_RST);
        rst = 1'b0;
        expect_cyc("idle_run", S_IDLE, O_RUN);
        load_use_rs8();
        expect_cyc("lu_bubble1", S_IDLE, O_BUB);
        ID_EX_MemRead = 1'b0;
        expect_cyc("lu_bubble2", S_LU, O_BUB);
        expect_cyc("lu_release", S_IDLE, O_RUN);
        clear_in(); ID_EX_MemRead = 1'b1; IF_ID_UsesRs = 1'b1;
        expect_cyc("zero_reg_no_stall", S_IDLE, O_RUN);
        ID_EX_Rt = 5'd8; IF_ID_Rt = 5'd8; IF_ID_UsesRs = 1'b0;
        expect_cyc("unused_rt_no_stall", S_IDLE, O_RUN);
        IF_ID_UsesRt = 1'b1;
        expect_cyc("rt_lu_bubble1", S_IDLE, O_BUB);
        ID_EX_MemRead = 1'b0;
        expect_cyc("rt_lu_bubble2", S_LU, O_BUB);
        clear_in(); MD_Start = 1'b1;
        expect_cyc("md_start", S_IDLE, O_RUN);
        MD_Start = 1'b0; IF_ID_UsesHiLo = 1'b1;
        expect_cyc("md_stall1", S_IDLE, O_BUB);
        expect_cyc("md_stall2", S_IDLE, O_BUB);
        expect_cyc("md_stall3", S_IDLE, O_BUB);
        expect_cyc("md_proceed", S_IDLE, O_RUN);
        clear_in(); load_use_rs8();
        expect_cyc("mw_lu_bubble1", S_IDLE, O_BUB);
        ID_EX_MemRead = 1'b0; EX_MEM_MemAccess = 1'b1; Mem_Ready = 1'b0;
        expect_cyc("mw_freeze1", S_LU, O_MEM);
        expect_cyc("mw_freeze2", S_MW, O_MEM);
        expect_cyc("mw_freeze3", S_MW, O_MEM);
        Mem_Ready = 1'b1;
        expect_cyc("mw_lu_bubble2", S_MW, O_BUB);
        clear_in();
        expect_cyc("mw_back_idle", S_IDLE, O_RUN);
        EX_MEM_MemAccess = 1'b1; Mem_Ready = 1'b0;
        expect_cyc("mw_from_idle", S_IDLE, O_MEM);
        Mem_Ready = 1'b1;
        expect_cyc("mw_ready_idle", S_MW, O_RUN);
        clear_in(); branch_Or_Jump = 2'b10;
        expect_cyc("taken_branch", S_IDLE, O_NB);
        branch_Or_Jump = 2'b11;
        expect_cyc("jump", S_IDLE, O_JMP);
        branch_Or_Jump = 2'b01;
        expect_cyc("branch_not_taken", S_IDLE, O_RUN);
        load_use_rs8(); branch_Or_Jump = 2'b11;
        expect_cyc("lu_jump_bubble1", S_IDLE, O_BUB);
        ID_EX_MemRead = 1'b0;
        expect_cyc("lu_jump_bubble2", S_LU, O_BUB);
        expect_cyc("lu_jump_taken", S_IDLE, O_JMP);
        clear_in(); MD_Start = 1'b1;
        expect_cyc("rst_md_start", S_IDLE, O_RUN);
        MD_Start = 1'b0; IF_ID_UsesHiLo = 1'b1; rst = 1'b1;
        expect_cyc("rst_mid_md", S_IDLE, O_RST);
        rst = 1'b0;
        expect_cyc("mflo_after_rst_md", S_IDLE, O_RUN);
        clear_in(); load_use_rs8();
        expect_cyc("rst_lu_bubble1", S_IDLE, O_BUB);
        ID_EX_MemRead = 1'b0; rst = 1'b1;
        expect_cyc("rst_mid_lu", S_LU, O_RST);
        rst = 1'b0; IF_ID_UsesHiLo = 1'b1;
        expect_cyc("mflo_after_rst_lu", S_IDLE, O_RUN);
        clear_in();
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
